mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Memory-side stage directly downstream of the address maker.
- Takes the 18-bit memory data address (MDAR) that stage produces, plus 8-bit write data, and runs one read or one write cycle on the external asynchronous SRAM.
- Applies fixed setup, strobe and hold timing, returns read data in MDDR_out, and raises busy/done so the control unit knows when to issue the next SEL/QUAD_inc/TOG_inc step.

Parameters:
ADDR_W, 18, address width; matches the MDAR width.
DATA_W, 8, data width of MDDR and the SRAM.
WAIT_CYC, 2, read access wait in clocks; legal range 1..15.
WE_CYC, 1, write strobe width in clocks; legal range 1..15.

Ports:
in_Clock  input  1  system clock; all logic on posedge.
in_Reset_n  input  1  asynchronous active-low reset.
MDAR  input  ADDR_W  address from the address maker; sampled only at request acceptance.
MDDR_in  input  DATA_W  write data; sampled only at write acceptance.
RD_req  input  1  read request, level, sampled on posedge.
WR_req  input  1  write request, level, sampled on posedge.
busy  output  1  transaction in progress.
done  output  1  one-cycle completion pulse.
MDDR_out  output  DATA_W  last captured read data.
mem_addr  output  ADDR_W  SRAM address.
mem_wdata  output  DATA_W  SRAM write data.
mem_rdata  input  DATA_W  SRAM read data.
mem_cs  output  1  SRAM chip select, active high.
mem_oe  output  1  SRAM output enable, active high.
mem_we  output  1  SRAM write enable, active high.

Behaviour:
Reset (in_Reset_n=0):
- Asynchronous; all outputs go to 0 immediately and state goes to IDLE.
- Applies mid-transaction too: mem_we/mem_cs drop at once, the transaction is discarded and no done is issued.
- After release, the first request is accepted at the first posedge.

States and counter:
- States: IDLE, RD_WAIT, WR_SETUP, WR_STROBE, WR_HOLD.
- Internal counter cnt is 4 bits and is cleared on every state entry.

IDLE:
- busy=0.
- At posedge E0 with WR_req=1: latch mem_addr<=MDAR and mem_wdata<=MDDR_in; mem_cs<=1, busy<=1; go to WR_SETUP.
- WR_req has priority if RD_req=1 at the same edge; the read is dropped, not queued.
- Otherwise, with RD_req=1: mem_addr<=MDAR; mem_cs<=1, mem_oe<=1, busy<=1; go to RD_WAIT.

RD_WAIT:
- cnt increments each edge.
- At the edge where cnt==WAIT_CYC-1: MDDR_out<=mem_rdata; mem_cs<=0, mem_oe<=0, busy<=0, done<=1; go to IDLE.
- Read data is captured at edge E0+WAIT_CYC (E2 for the default).

WR_SETUP:
- One cycle, with address and data stable.
- Next edge: mem_we<=1, go to WR_STROBE.

WR_STROBE:
- Lasts WE_CYC cycles.
- At the edge where cnt==WE_CYC-1: mem_we<=0, go to WR_HOLD.

WR_HOLD:
- One cycle; mem_cs, mem_addr and mem_wdata stay stable.
- Next edge: mem_cs<=0, busy<=0, done<=1; go to IDLE.
- Write completes at edge E0+WE_CYC+2 (E3 for the default).

done:
- High for exactly one cycle, the cycle after the completion edge.
- busy is already 0 during that cycle, so a new request may be accepted at the edge that ends done (back-to-back operation).

Hold and ignore rules:
- Requests while busy=1 are ignored, not queued; the control unit must hold the request or re-issue it after done.
- A request held high across completion starts a new transaction at the first IDLE edge.
- MDAR and MDDR_in changes while busy do not affect mem_addr, mem_wdata or MDDR_out.

Output stability:
- mem_oe and mem_we are never high simultaneously.
- mem_we is never high while mem_addr can change.
- MDDR_out keeps its value until the next read capture; writes do not alter it.
- mem_addr and mem_wdata hold their last values in IDLE; they are not cleared.

Test Plan:
- Reset, then RD_req=1 for one cycle at E0 with MDAR=18'h2A5C3 and mem_rdata=8'h9E -> mem_addr=18'h2A5C3, mem_cs=mem_oe=1 for cycles E0..E2, MDDR_out=8'h9E at E2, done=1 for one cycle only, busy=0 after E2.
- WR_req at E0 with MDAR=18'h00001 and MDDR_in=8'h55 -> mem_we=1 only between E1 and E2, mem_cs=1 between E0 and E3, done pulses after E3, MDDR_out unchanged.
- RD_req=WR_req=1 at the same edge -> write sequence runs, mem_oe stays 0, exactly one done pulse.
- RD_req held high continuously with MDAR changing every cycle -> consecutive reads each capture the MDAR present at their acceptance edge, one done per read, no gap cycles beyond the done cycle.
- Assert in_Reset_n=0 during WR_STROBE -> mem_we, mem_cs and busy go to 0 without waiting for a clock edge, no done; after release a read completes normally.
- WAIT_CYC=5 and WE_CYC=3 instance -> read capture at E5, write done edge at E5; mem_oe and mem_we are never overlapping in any cycle.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Single-transaction SRAM access controller: runs one read or one write cycle with fixed setup/strobe/hold timing.
// Requests arriving while busy are dropped; done pulses for one cycle after each completed transaction.
module mem_access_ctrl #(
   parameter int ADDR_W   = 18,
   parameter int DATA_W   = 8,
   parameter int WAIT_CYC = 2,
   parameter int WE_CYC   = 1
) (
   input  logic              in_Clock,
   input  logic              in_Reset_n,
   input  logic [ADDR_W-1:0] MDAR,
   input  logic [DATA_W-1:0] MDDR_in,
   input  logic              RD_req,
   input  logic              WR_req,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] MDDR_out,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              mem_cs,
   output logic              mem_oe,
   output logic              mem_we
);

   // state     | meaning
   // IDLE      | no transaction; accepts WR_req (priority) or RD_req
   // RD_WAIT   | cs/oe asserted, waiting WAIT_CYC clocks for read data
   // WR_SETUP  | address/data stable one cycle before the write strobe
   // WR_STROBE | mem_we asserted for WE_CYC clocks
   // WR_HOLD   | strobe released, address/data held one more cycle
   typedef enum logic [2:0] {
      IDLE,
      RD_WAIT,
      WR_SETUP,
      WR_STROBE,
      WR_HOLD
   } state_t;

   localparam logic [3:0] RD_LAST = 4'(WAIT_CYC - 1);
   localparam logic [3:0] WR_LAST = 4'(WE_CYC - 1);

   state_t            state, state_nxt;
   logic [3:0]        cnt, cnt_nxt;
   logic              busy_nxt, done_nxt, cs_nxt, oe_nxt, we_nxt;
   logic [ADDR_W-1:0] addr_nxt;
   logic [DATA_W-1:0] wdata_nxt, rout_nxt;

   always_ff @(posedge in_Clock or negedge in_Reset_n) begin
      if (!in_Reset_n) begin
         state     <= IDLE;
         cnt       <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         MDDR_out  <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_cs    <= 1'b0;
         mem_oe    <= 1'b0;
         mem_we    <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
         MDDR_out  <= rout_nxt;
         mem_addr  <= addr_nxt;
         mem_wdata <= wdata_nxt;
         mem_cs    <= cs_nxt;
         mem_oe    <= oe_nxt;
         mem_we    <= we_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + 4'd1;
      busy_nxt  = busy;
      done_nxt  = 1'b0;
      rout_nxt  = MDDR_out;
      addr_nxt  = mem_addr;
      wdata_nxt = mem_wdata;
      cs_nxt    = mem_cs;
      oe_nxt    = mem_oe;
      we_nxt    = mem_we;

      unique case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (WR_req) begin
               addr_nxt  = MDAR;
               wdata_nxt = MDDR_in;
               cs_nxt    = 1'b1;
               busy_nxt  = 1'b1;
               state_nxt = WR_SETUP;
            end else if (RD_req) begin
               addr_nxt  = MDAR;
               cs_nxt    = 1'b1;
               oe_nxt    = 1'b1;
               busy_nxt  = 1'b1;
               state_nxt = RD_WAIT;
            end
         end
         RD_WAIT: begin
            if (cnt == RD_LAST) begin
               rout_nxt  = mem_rdata;
               cs_nxt    = 1'b0;
               oe_nxt    = 1'b0;
               busy_nxt  = 1'b0;
               done_nxt  = 1'b1;
               cnt_nxt   = '0;
               state_nxt = IDLE;
            end
         end
         WR_SETUP: begin
            we_nxt    = 1'b1;
            cnt_nxt   = '0;
            state_nxt = WR_STROBE;
         end
         WR_STROBE: begin
            if (cnt == WR_LAST) begin
               we_nxt    = 1'b0;
               cnt_nxt   = '0;
               state_nxt = WR_HOLD;
            end
         end
         WR_HOLD: begin
            cs_nxt    = 1'b0;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            cnt_nxt   = '0;
            state_nxt = IDLE;
         end
         default: begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: a default-timing and a slow-timing instance share stimulus and are each
// checked every cycle against a transaction-level model, plus directed vectors and corner sequences.
module tb_mem_access_ctrl;

   localparam int W0 = 2, E0 = 1;
   localparam int W1 = 5, E1 = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [17:0] MDAR;
   logic [7:0]  MDDR_in, mem_rdata;
   logic        RD_req, WR_req;

   logic        busy0, done0, cs0, oe0, we0;
   logic [7:0]  out0, wdata0;
   logic [17:0] addr0;
   logic        busy1, done1, cs1, oe1, we1;
   logic [7:0]  out1, wdata1;
   logic [17:0] addr1;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mem_access_ctrl #(.ADDR_W(18), .DATA_W(8), .WAIT_CYC(W0), .WE_CYC(E0)) dut0 (
      .in_Clock(clk), .in_Reset_n(rst_n), .MDAR(MDAR), .MDDR_in(MDDR_in),
      .RD_req(RD_req), .WR_req(WR_req), .busy(busy0), .done(done0), .MDDR_out(out0),
      .mem_addr(addr0), .mem_wdata(wdata0), .mem_rdata(mem_rdata),
      .mem_cs(cs0), .mem_oe(oe0), .mem_we(we0));

   mem_access_ctrl #(.ADDR_W(18), .DATA_W(8), .WAIT_CYC(W1), .WE_CYC(E1)) dut1 (
      .in_Clock(clk), .in_Reset_n(rst_n), .MDAR(MDAR), .MDDR_in(MDDR_in),
      .RD_req(RD_req), .WR_req(WR_req), .busy(busy1), .done(done1), .MDDR_out(out1),
      .mem_addr(addr1), .mem_wdata(wdata1), .mem_rdata(mem_rdata),
      .mem_cs(cs1), .mem_oe(oe1), .mem_we(we1));

   // Transaction-level model: age counts edges since acceptance; outputs derive from age and length.
   typedef struct {
      bit          act;
      bit          wr;
      int          age;
      logic [17:0] addr;
      logic [7:0]  wd;
      logic [7:0]  rout;
      bit          done;
   } mdl_t;

   mdl_t m0, m1;

   function automatic mdl_t mdl_step(mdl_t m, int wait_c, int we_c, bit rd, bit wr,
                                     logic [17:0] a, logic [7:0] d, logic [7:0] rdat);
      mdl_t n = m;
      n.done = 1'b0;
      if (m.act) begin
         n.age = m.age + 1;
         if (n.age == (m.wr ? we_c + 2 : wait_c)) begin
            n.act  = 1'b0;
            n.done = 1'b1;
            if (!m.wr) n.rout = rdat;
         end
      end else if (wr) begin
         n.act = 1'b1; n.wr = 1'b1; n.age = 0; n.addr = a; n.wd = d;
      end else if (rd) begin
         n.act = 1'b1; n.wr = 1'b0; n.age = 0; n.addr = a;
      end
      return n;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m0 = '{default: '0};
         m1 = '{default: '0};
      end else begin
         m0 = mdl_step(m0, W0, E0, RD_req, WR_req, MDAR, MDDR_in, mem_rdata);
         m1 = mdl_step(m1, W1, E1, RD_req, WR_req, MDAR, MDDR_in, mem_rdata);
      end
   end

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: actual=%0h required=%0h", nm, $time, act, exp);
      end
   endtask

   task automatic chk_dut(string tag, mdl_t m, int we_c, logic busy, logic done, logic cs,
                          logic oe, logic we, logic [17:0] addr, logic [7:0] wdata,
                          logic [7:0] rout);
      chk({tag, "_busy"},  32'(busy), 32'(m.act));
      chk({tag, "_done"},  32'(done), 32'(m.done));
      chk({tag, "_cs"},    32'(cs),   32'(m.act));
      chk({tag, "_oe"},    32'(oe),   32'(m.act && !m.wr));
      chk({tag, "_we"},    32'(we),   32'(m.act && m.wr && m.age >= 1 && m.age <= we_c));
      chk({tag, "_addr"},  32'(addr), 32'(m.addr));
      chk({tag, "_wdata"}, 32'(wdata), 32'(m.wd));
      chk({tag, "_mddr_out"}, 32'(rout), 32'(m.rout));
      chk({tag, "_oe_we_overlap"}, 32'(oe & we), 32'd0);
   endtask

   always @(negedge clk) begin
      chk_dut("def",  m0, E0, busy0, done0, cs0, oe0, we0, addr0, wdata0, out0);
      chk_dut("slow", m1, E1, busy1, done1, cs1, oe1, we1, addr1, wdata1, out1);
   end

   typedef struct {
      bit          rd;
      bit          wr;
      logic [17:0] addr;
      logic [7:0]  wd;
      logic [7:0]  rdat;
      logic [7:0]  exp_out;
      int          lat0;
      int          lat1;
   } vec_t;

   vec_t vecs[6];

   task automatic apply_vec(vec_t v);
      int k, k0, k1;
      @(negedge clk);
      RD_req = v.rd; WR_req = v.wr; MDAR = v.addr; MDDR_in = v.wd; mem_rdata = v.rdat;
      @(posedge clk);
      @(negedge clk);
      RD_req = 1'b0; WR_req = 1'b0; MDAR = ~v.addr; MDDR_in = ~v.wd;
      k = 0; k0 = -1; k1 = -1;
      while ((k0 < 0 || k1 < 0) && k < 20) begin
         @(posedge clk); #1;
         k++;
         if (done0 && k0 < 0) k0 = k;
         if (done1 && k1 < 0) k1 = k;
      end
      chk("vec_lat_def",  32'(k0), 32'(v.lat0));
      chk("vec_lat_slow", 32'(k1), 32'(v.lat1));
      chk("vec_out_def",  32'(out0), 32'(v.exp_out));
      chk("vec_out_slow", 32'(out1), 32'(v.exp_out));
      chk("vec_addr_def", 32'(addr0), 32'(v.addr));
      if (v.wr) chk("vec_wdata_def", 32'(wdata0), 32'(v.wd));
      @(posedge clk); #1;
      chk("vec_done_single", 32'({done0, done1}), 32'd0);
      chk("vec_idle", 32'({busy0, busy1}), 32'd0);
   endtask

   initial begin
      int c0, c1;
      vecs[0] = '{1'b1, 1'b0, 18'h2A5C3, 8'h00, 8'h9E, 8'h9E, W0, W1};
      vecs[1] = '{1'b0, 1'b1, 18'h00001, 8'h55, 8'h33, 8'h9E, E0 + 2, E1 + 2};
      vecs[2] = '{1'b1, 1'b1, 18'h3FFFF, 8'hAA, 8'h11, 8'h9E, E0 + 2, E1 + 2};
      vecs[3] = '{1'b1, 1'b0, 18'h00000, 8'hFF, 8'h00, 8'h00, W0, W1};
      vecs[4] = '{1'b1, 1'b0, 18'h3FFFF, 8'h12, 8'hFF, 8'hFF, W0, W1};
      vecs[5] = '{1'b0, 1'b1, 18'h12345, 8'h0F, 8'hC3, 8'hFF, E0 + 2, E1 + 2};

      rst_n = 1'b0; RD_req = 1'b0; WR_req = 1'b0;
      MDAR = '0; MDDR_in = '0; mem_rdata = '0;
      repeat (2) @(negedge clk);
      chk("reset_state", 32'({busy0, done0, cs0, oe0, we0, busy1, cs1}), 32'd0);
      rst_n = 1'b1;

      foreach (vecs[i]) apply_vec(vecs[i]);

      // Reset asserted while both instances are strobing a write.
      @(negedge clk);
      WR_req = 1'b1; MDAR = 18'h1ABCD; MDDR_in = 8'h5A;
      @(posedge clk);
      @(negedge clk);
      WR_req = 1'b0;
      @(posedge clk); #2;
      chk("pre_reset_we", 32'({we0, we1}), 32'h3);
      rst_n = 1'b0;
      #1;
      chk("async_reset_drop", 32'({we0, cs0, busy0, we1, cs1, busy1, done0, done1}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      vecs[0].exp_out = 8'h9E;
      apply_vec(vecs[0]);

      // Held read request: back-to-back reads with MDAR moving every cycle.
      @(negedge clk);
      RD_req = 1'b1;
      c0 = 0; c1 = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk);
         @(negedge clk);
         MDAR = 18'($urandom);
         mem_rdata = 8'($urandom);
         if (done0) c0++;
         if (done1) c1++;
      end
      RD_req = 1'b0;
      chk("b2b_done_def",  32'(c0), 32'd10);
      chk("b2b_done_slow", 32'(c1), 32'd5);

      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         RD_req    = ($urandom_range(0, 2) == 0);
         WR_req    = ($urandom_range(0, 3) == 0);
         MDAR      = 18'($urandom);
         MDDR_in   = 8'($urandom);
         mem_rdata = 8'($urandom);
      end
      @(negedge clk);
      RD_req = 1'b0; WR_req = 1'b0;
      repeat (12) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
